// File: rtl/ro_pair_meter_if.sv
// Request/result bundle between the RO-pair meter and its controller.
// master: controller side (issues start, accepts the result with ready).
// slave : meter side (reports busy and the held result).
// With RO_PAIR_METER_DIFF_EN defined, a signed count difference is added.
interface ro_pair_meter_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             ready;
  logic             busy;
  logic             valid;
  logic             resp;
  logic             tie;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
`ifdef RO_PAIR_METER_DIFF_EN
  logic signed [CNT_W:0] diff;

  modport master (output start, ready,
                  input  busy, valid, resp, tie, cnt_a, cnt_b, diff);
  modport slave  (input  start, ready,
                  output busy, valid, resp, tie, cnt_a, cnt_b, diff);
`else
  modport master (output start, ready,
                  input  busy, valid, resp, tie, cnt_a, cnt_b);
  modport slave  (input  start, ready,
                  output busy, valid, resp, tie, cnt_a, cnt_b);
`endif
endinterface

// File: rtl/ro_pair_meter.sv
// RO-PUF measurement end: enables a ring-oscillator pair, counts the
// synchronized rising edges of each over a fixed window of clk cycles and
// reports which one ran faster as a single response bit.
// Optional feature macro: RO_PAIR_METER_DIFF_EN adds bus.diff = cnt_a - cnt_b.
module ro_pair_meter #(
  parameter int CNT_W  = 16,
  parameter int SETTLE = 8,
  parameter int WINDOW = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ro_a,
  input  logic               ro_b,
  output logic               ro_en_a,
  output logic               ro_en_b,
  ro_pair_meter_if.slave     bus
);

  // Timer must also reach the 3-cycle drain count.
  localparam int TMR_MAX = (SETTLE > WINDOW) ? ((SETTLE > 3) ? SETTLE : 3)
                                             : ((WINDOW > 3) ? WINDOW : 3);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_COUNT  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [TMR_W-1:0] tmr;
  logic             ro_en;
  logic             ro_a_p0, ro_a_p1, ro_a_p2;
  logic             ro_b_p0, ro_b_p1, ro_b_p2;
  logic             edge_a, edge_b, count_en;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Synchronizer (p0,p1) plus previous-value flop (p2) for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_a_p0 <= 1'b0; ro_a_p1 <= 1'b0; ro_a_p2 <= 1'b0;
      ro_b_p0 <= 1'b0; ro_b_p1 <= 1'b0; ro_b_p2 <= 1'b0;
    end else begin
      ro_a_p0 <= ro_a; ro_a_p1 <= ro_a_p0; ro_a_p2 <= ro_a_p1;
      ro_b_p0 <= ro_b; ro_b_p1 <= ro_b_p0; ro_b_p2 <= ro_b_p1;
    end
  end

  assign edge_a = ro_a_p1 & ~ro_a_p2;
  assign edge_b = ro_b_p1 & ~ro_b_p2;

  // The last drain cycle does not count, so the compare sees settled counts.
  assign count_en = (state == S_COUNT) ||
                    ((state == S_DRAIN) && (tmr != TMR_W'(2)));

  // Sequencer: settle, count window, drain sync pipe, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tmr       <= '0;
      ro_en     <= 1'b0;
      bus.valid <= 1'b0;
      bus.resp  <= 1'b0;
      bus.tie   <= 1'b0;
`ifdef RO_PAIR_METER_DIFF_EN
      bus.diff  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_SETTLE;
            tmr   <= '0;
            ro_en <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (tmr == TMR_W'(SETTLE - 1)) begin
            state <= S_COUNT;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_COUNT: begin
          if (tmr == TMR_W'(WINDOW - 1)) begin
            state <= S_DRAIN;
            tmr   <= '0;
            ro_en <= 1'b0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_DRAIN: begin
          if (tmr == TMR_W'(2)) begin
            state     <= S_DONE;
            tmr       <= '0;
            bus.valid <= 1'b1;
            bus.resp  <= (cnt_a > cnt_b);
            bus.tie   <= (cnt_a == cnt_b);
`ifdef RO_PAIR_METER_DIFF_EN
            bus.diff  <= $signed({1'b0, cnt_a}) - $signed({1'b0, cnt_b});
`endif
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_DONE: begin
          if (bus.ready) begin
            state     <= S_IDLE;
            bus.valid <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          tmr   <= '0;
          ro_en <= 1'b0;
        end
      endcase
    end
  end

  // Saturating edge counters, cleared while the oscillators settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (state == S_SETTLE) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (count_en) begin
      if (edge_a) cnt_a <= sat_inc(cnt_a);
      if (edge_b) cnt_b <= sat_inc(cnt_b);
    end
  end

  assign ro_en_a   = ro_en;
  assign ro_en_b   = ro_en;
  assign bus.busy  = (state != S_IDLE);
  assign bus.cnt_a = cnt_a;
  assign bus.cnt_b = cnt_b;

endmodule

// File: tb/tb_ro_pair_meter.sv
// Directed bench for ro_pair_meter: a main instance (CNT_W=16, SETTLE=8,
// WINDOW=64) and a narrow instance (CNT_W=4, SETTLE=4, WINDOW=64) for
// counter saturation. Oscillators are modelled as divided clocks gated by
// the enables, or as a fixed number of 4-cycle pulses.
module tb_ro_pair_meter;

  localparam int SM = 8;
  localparam int WM = 64;
  localparam int SS = 4;
  localparam int WS = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic ro_a = 1'b0;
  logic ro_b = 1'b0;
  logic m_en_a, m_en_b, s_en_a, s_en_b;

  int total = 0;
  int bad   = 0;

  // generator controls: per_* = half period in clk cycles (0 = off),
  // manual pulses while done_* < tgt_*
  int per_a = 0, per_b = 0;
  int ph_a = 0, ph_b = 0;
  int tgt_a = 0, tgt_b = 0;
  int done_a = 0, done_b = 0;

  ro_pair_meter_if #(.CNT_W(16)) m_if ();
  ro_pair_meter_if #(.CNT_W(4))  s_if ();

  ro_pair_meter #(.CNT_W(16), .SETTLE(SM), .WINDOW(WM)) u_main (
    .clk(clk), .rst_n(rst_n), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en_a(m_en_a), .ro_en_b(m_en_b), .bus(m_if.slave));

  ro_pair_meter #(.CNT_W(4), .SETTLE(SS), .WINDOW(WS)) u_sat (
    .clk(clk), .rst_n(rst_n), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en_a(s_en_a), .ro_en_b(s_en_b), .bus(s_if.slave));

  always #5 clk = ~clk;

  // oscillator A model
  always @(negedge clk) begin
    if (per_a != 0) begin
      if (m_en_a | s_en_a) begin
        ph_a++;
        if (ph_a >= per_a) begin ph_a = 0; ro_a = ~ro_a; end
      end
    end else if (done_a < tgt_a) begin
      ph_a++;
      if (ph_a >= 2) begin ph_a = 0; if (ro_a) done_a++; ro_a = ~ro_a; end
    end else begin
      ph_a = 0; ro_a = 1'b0;
    end
  end

  // oscillator B model
  always @(negedge clk) begin
    if (per_b != 0) begin
      if (m_en_b | s_en_b) begin
        ph_b++;
        if (ph_b >= per_b) begin ph_b = 0; ro_b = ~ro_b; end
      end
    end else if (done_b < tgt_b) begin
      ph_b++;
      if (ph_b >= 2) begin ph_b = 0; if (ro_b) done_b++; ro_b = ~ro_b; end
    end else begin
      ph_b = 0; ro_b = 1'b0;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // start a run (called 1ns after a posedge) and wait for valid
  task automatic run(input bit sat, input int npa, input int npb,
                     input int exp_lat, input string tag);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    if (sat) s_if.start = 1'b1; else m_if.start = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      m_if.start = 1'b0;
      s_if.start = 1'b0;
      lat++;
      if (lat == SM + 2 && (npa != 0 || npb != 0)) begin
        tgt_a = done_a + npa;
        tgt_b = done_b + npb;
      end
      got = sat ? s_if.valid : m_if.valid;
    end
    chk({tag, " latency"}, got ? lat : -1, exp_lat);
  endtask

  // stop both free-running models and restart them in phase
  task automatic reseed(input int pa, input int pb);
    per_a = 0; per_b = 0;
    @(negedge clk); #1;
    per_a = pa; per_b = pb;
  endtask

  initial begin
    m_if.start = 1'b0; m_if.ready = 1'b1;
    s_if.start = 1'b0; s_if.ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // ---- reset state
    chk("rst busy",  m_if.busy, 0);
    chk("rst valid", m_if.valid, 0);
    chk("rst resp",  m_if.resp, 0);
    chk("rst tie",   m_if.tie, 0);
    chk("rst cnt_a", m_if.cnt_a, 0);
    chk("rst cnt_b", m_if.cnt_b, 0);
    chk("rst en_a",  m_en_a, 0);
    chk("rst en_b",  m_en_b, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- A = clk/4, B = clk/8
    per_a = 2; per_b = 4;
    run(1'b0, 0, 0, SM + WM + 4, "r1");
    chk("r1 cnt_a 15..17", (m_if.cnt_a >= 15 && m_if.cnt_a <= 17), 1);
    chk("r1 cnt_b 7..9",   (m_if.cnt_b >= 7  && m_if.cnt_b <= 9), 1);
    chk("r1 resp", m_if.resp, 1);
    chk("r1 tie",  m_if.tie, 0);
    reseed(3, 3);
    @(posedge clk); #1;
    chk("r1 accepted", m_if.busy, 0);

    // ---- identical stimulus, started in the first IDLE cycle
    run(1'b0, 0, 0, SM + WM + 4, "r2");
    chk("r2 equal counts", (m_if.cnt_a == m_if.cnt_b), 1);
    chk("r2 cnt_a 10..12", (m_if.cnt_a >= 10 && m_if.cnt_a <= 12), 1);
    chk("r2 tie",  m_if.tie, 1);
    chk("r2 resp", m_if.resp, 0);
    per_a = 0; per_b = 0;
    @(posedge clk); #1;

    // ---- exact 10 vs 13 pulses, result held with ready low
    m_if.ready = 1'b0;
    run(1'b0, 10, 13, SM + WM + 4, "r3");
    chk("r3 cnt_a", m_if.cnt_a, 10);
    chk("r3 cnt_b", m_if.cnt_b, 13);
    chk("r3 resp",  m_if.resp, 0);
    chk("r3 tie",   m_if.tie, 0);
`ifdef RO_PAIR_METER_DIFF_EN
    chk("r3 diff",  m_if.diff, -3);
`endif
    for (int i = 0; i < 20; i++) begin
      if (i == 5) m_if.start = 1'b1;
      @(posedge clk); #1;
      m_if.start = 1'b0;
      chk("hold valid", m_if.valid, 1);
      chk("hold busy",  m_if.busy, 1);
      chk("hold cnt_a", m_if.cnt_a, 10);
      chk("hold cnt_b", m_if.cnt_b, 13);
    end
    m_if.ready = 1'b1;
    @(posedge clk); #1;
    chk("r3 accept busy",  m_if.busy, 0);
    chk("r3 accept valid", m_if.valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("no queued start", m_if.busy, 0);

    // ---- reset in the middle of COUNT
    reseed(2, 4);
    m_if.start = 1'b1;
    @(posedge clk); #1;
    m_if.start = 1'b0;
    repeat (SM + 30) @(posedge clk);
    #1;
    chk("mid busy", m_if.busy, 1);
    chk("mid cnt_a nonzero", (m_if.cnt_a > 0), 1);
    rst_n = 1'b0;
    #1;
    chk("arst busy",  m_if.busy, 0);
    chk("arst valid", m_if.valid, 0);
    chk("arst en_a",  m_en_a, 0);
    chk("arst en_b",  m_en_b, 0);
    chk("arst cnt_a", m_if.cnt_a, 0);
    chk("arst cnt_b", m_if.cnt_b, 0);
    @(negedge clk) rst_n = 1'b1;
    reseed(1, 8);
    @(posedge clk); #1;

    // ---- narrow counters: A = clk/2 saturates
    run(1'b1, 0, 0, SS + WS + 4, "s1");
    chk("s1 cnt_a sat", s_if.cnt_a, 15);
    chk("s1 cnt_b 3..5", (s_if.cnt_b >= 3 && s_if.cnt_b <= 5), 1);
    chk("s1 resp", s_if.resp, 1);
    chk("s1 tie",  s_if.tie, 0);
    reseed(1, 1);
    @(posedge clk); #1;
    chk("s1 accepted", s_if.busy, 0);

    // ---- both saturate -> tie
    run(1'b1, 0, 0, SS + WS + 4, "s2");
    chk("s2 cnt_a sat", s_if.cnt_a, 15);
    chk("s2 cnt_b sat", s_if.cnt_b, 15);
    chk("s2 tie",  s_if.tie, 1);
    chk("s2 resp", s_if.resp, 0);
    per_a = 0; per_b = 0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
